// File: rtl/irq_arb_pkg.sv
// Shared types and helpers for the pipelined interrupt priority arbiter.
package irq_arb_pkg;

  localparam int unsigned ARB_KEY_MAX_W = 33;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

  // B wins only when eligible and strictly greater; ties stay with the lower index (A).
  function automatic sel_e arb_sel(
    input logic                     valid_a,
    input logic                     valid_b,
    input logic [ARB_KEY_MAX_W-1:0] key_a,
    input logic [ARB_KEY_MAX_W-1:0] key_b
  );
    sel_e sel;
    sel = SEL_A;
    if (valid_b && (!valid_a || (key_b > key_a))) begin
      sel = SEL_B;
    end
    return sel;
  endfunction

  // True when the output of tree level lvl (0 = nearest the leaves) is registered.
  function automatic logic stage_reg_at(
    input int unsigned lvl,
    input int unsigned every,
    input int unsigned levels
  );
    logic hit;
    hit = 1'b0;
    if (lvl == levels - 1) begin
      hit = 1'b1;
    end else if (every != 0) begin
      hit = ((lvl % every) == (every - 1));
    end
    return hit;
  endfunction

endpackage

// File: rtl/irq_arb_node.sv
// Combinational 2:1 compare node; forwards the winning {valid, key, idx} triple.
module irq_arb_node
  import irq_arb_pkg::*;
#(
  parameter int unsigned KeyWidth = 8,
  parameter int unsigned IdxWidth = 6
) (
  input  logic                a_valid,
  input  logic [KeyWidth-1:0] a_key,
  input  logic [IdxWidth-1:0] a_idx,
  input  logic                b_valid,
  input  logic [KeyWidth-1:0] b_key,
  input  logic [IdxWidth-1:0] b_idx,
  output logic                win_valid_c,
  output logic [KeyWidth-1:0] win_key_c,
  output logic [IdxWidth-1:0] win_idx_c
);

  sel_e sel_c;

  // An empty node collapses to an all-zero triple so downstream stages see clean zeros.
  always_comb begin
    win_valid_c = 1'b0;
    win_key_c   = '0;
    win_idx_c   = '0;
    sel_c       = arb_sel(a_valid, b_valid,
                          ARB_KEY_MAX_W'(a_key), ARB_KEY_MAX_W'(b_key));
    if (sel_c == SEL_B) begin
      win_valid_c = 1'b1;
      win_key_c   = b_key;
      win_idx_c   = b_idx;
    end else if (a_valid) begin
      win_valid_c = 1'b1;
      win_key_c   = a_key;
      win_idx_c   = a_idx;
    end
  end

endmodule

// File: rtl/irq_arbiter_pipe.sv
// Pipelined, stall-aware threshold/priority interrupt arbiter with valid/ready output.
// Define IRQ_ARB_RR_EN for round-robin tie-breaking among equal priorities.
module irq_arbiter_pipe
  import irq_arb_pkg::*;
#(
  parameter int unsigned NrInputs  = 64,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned PipeEvery = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NrInputs-1:0]           valid_i,
  input  logic [NrInputs*PrioWidth-1:0] prio_i,
  input  logic [PrioWidth-1:0]          thresh_i,
  input  logic                          flush_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [PrioWidth-1:0]          prio_o,
  output logic [$clog2(NrInputs)-1:0]   idx_o
);

  localparam int unsigned IdxWidth = $clog2(NrInputs);
  localparam int unsigned NrNodes  = 2 * NrInputs;
`ifdef IRQ_ARB_RR_EN
  localparam int unsigned KeyWidth = PrioWidth + 1;
`else
  localparam int unsigned KeyWidth = PrioWidth;
`endif

  logic advance;
  logic squash;
  logic handshake;

  // Whole pipe freezes while a winner waits; a claim or flush empties every stage.
  assign handshake = valid_o && ready_i;
  assign advance   = !(valid_o && !ready_i);
  assign squash    = flush_i || handshake;

`ifdef IRQ_ARB_RR_EN
  logic [IdxWidth-1:0] last_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_idx <= '0;
    end else if (handshake) begin
      last_idx <= idx_o;
    end
  end
`endif

  // Heap-ordered tree: node 1 is the root, children of k are 2k and 2k+1, leaves at NrInputs+i.
  for (genvar k = 1; k < NrNodes; k++) begin : g_tree
    logic                 o_valid;
    logic [PrioWidth-1:0] o_prio;
    logic [IdxWidth-1:0]  o_idx;

    if (k >= NrInputs) begin : g_leaf
      logic [PrioWidth-1:0] prio;
      assign prio    = prio_i[(k-NrInputs)*PrioWidth +: PrioWidth];
      assign o_valid = valid_i[k-NrInputs] && (prio > thresh_i);
      assign o_prio  = prio;
      assign o_idx   = IdxWidth'(k - NrInputs);
    end else begin : g_node
      localparam int unsigned Lvl = IdxWidth - $clog2(k + 1);

      logic [KeyWidth-1:0]  key_a;
      logic [KeyWidth-1:0]  key_b;
      logic                 win_valid;
      logic [KeyWidth-1:0]  win_key;
      logic [IdxWidth-1:0]  win_idx;
      logic [PrioWidth-1:0] win_prio;

`ifdef IRQ_ARB_RR_EN
      // LSB marks lines after the last claim so equal priorities rotate.
      assign key_a = {g_tree[2*k].o_prio,   g_tree[2*k].o_idx   > last_idx};
      assign key_b = {g_tree[2*k+1].o_prio, g_tree[2*k+1].o_idx > last_idx};
`else
      assign key_a = g_tree[2*k].o_prio;
      assign key_b = g_tree[2*k+1].o_prio;
`endif

      irq_arb_node #(
        .KeyWidth (KeyWidth),
        .IdxWidth (IdxWidth)
      ) u_node (
        .a_valid     (g_tree[2*k].o_valid),
        .a_key       (key_a),
        .a_idx       (g_tree[2*k].o_idx),
        .b_valid     (g_tree[2*k+1].o_valid),
        .b_key       (key_b),
        .b_idx       (g_tree[2*k+1].o_idx),
        .win_valid_c (win_valid),
        .win_key_c   (win_key),
        .win_idx_c   (win_idx)
      );

      assign win_prio = PrioWidth'(win_key >> (KeyWidth - PrioWidth));

      if (stage_reg_at(Lvl, PipeEvery, IdxWidth)) begin : g_reg
        logic                 r_valid;
        logic [PrioWidth-1:0] r_prio;
        logic [IdxWidth-1:0]  r_idx;

        always_ff @(posedge clk_i) begin
          if (rst_i || squash) begin
            r_valid <= 1'b0;
            r_prio  <= '0;
            r_idx   <= '0;
          end else if (advance) begin
            r_valid <= win_valid;
            r_prio  <= win_prio;
            r_idx   <= win_idx;
          end
        end

        assign o_valid = r_valid;
        assign o_prio  = r_prio;
        assign o_idx   = r_idx;
      end else begin : g_comb
        assign o_valid = win_valid;
        assign o_prio  = win_prio;
        assign o_idx   = win_idx;
      end
    end
  end

  // The root is always a registered level, so these are register outputs.
  assign valid_o = g_tree[1].o_valid;
  assign prio_o  = g_tree[1].o_prio;
  assign idx_o   = g_tree[1].o_idx;

endmodule

// File: tb/tb_irq_arbiter_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic against a whole-tree
// reference model with an S-deep result latency; a second instance sweeps a 64-line, S=1 build.
module tb_irq_arbiter_pipe;

  localparam int unsigned N    = 8;
  localparam int unsigned PW   = 4;
  localparam int unsigned S    = 3;
  localparam int unsigned N64  = 64;
  localparam int unsigned PW64 = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          ready;
  logic [N-1:0]  vin;
  logic [N*PW-1:0] pin;
  logic [PW-1:0] thr;
  logic          vout;
  logic [PW-1:0] pout;
  logic [2:0]    iout;

  logic [N64-1:0]      v64;
  logic [N64*PW64-1:0] p64;
  logic                vout64;
  logic [PW64-1:0]     pout64;
  logic [5:0]          iout64;

  int n_vec;
  int n_err;

  // Reference: result produced S advancing edges ago; index S-1 is what the outputs show.
  bit m_v [S];
  int m_p [S];
  int m_i [S];
  int m_last;

  always #5 clk = ~clk;

  irq_arbiter_pipe #(.NrInputs(N), .PrioWidth(PW), .PipeEvery(1)) u_dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (vin),
    .prio_i   (pin),
    .thresh_i (thr),
    .flush_i  (flush),
    .valid_o  (vout),
    .ready_i  (ready),
    .prio_o   (pout),
    .idx_o    (iout)
  );

  irq_arbiter_pipe #(.NrInputs(N64), .PrioWidth(PW64), .PipeEvery(0)) u_dut64 (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (v64),
    .prio_i   (p64),
    .thresh_i (8'd0),
    .flush_i  (1'b0),
    .valid_o  (vout64),
    .ready_i  (1'b1),
    .prio_o   (pout64),
    .idx_o    (iout64)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int prio_of(input int i);
    return int'(pin[i*PW +: PW]);
  endfunction

  function automatic bit elig(input int i);
    return vin[i] && (prio_of(i) > int'(thr));
  endfunction

  // Highest eligible priority; ties to the first line after the last claim (RR) or lowest line.
  function automatic void ref_winner(output bit v, output int p, output int ix);
    int best;
    best = -1;
    v = 1'b0;
    p = 0;
    ix = -1;
    for (int i = 0; i < N; i++)
      if (elig(i) && prio_of(i) > best) best = prio_of(i);
    if (best >= 0) begin
`ifdef IRQ_ARB_RR_EN
      for (int i = 0; i < N; i++)
        if (ix < 0 && elig(i) && prio_of(i) == best && i > m_last) ix = i;
`endif
      for (int i = 0; i < N; i++)
        if (ix < 0 && elig(i) && prio_of(i) == best) ix = i;
      v = 1'b1;
      p = best;
    end else begin
      ix = 0;
    end
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < S; s++) begin
      m_v[s] = 1'b0;
      m_p[s] = 0;
      m_i[s] = 0;
    end
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  function automatic void model_edge();
    bit hs;
    bit wv;
    int wp;
    int wi;
    hs = m_v[S-1] && ready;
    ref_winner(wv, wp, wi);
    if (rst) begin
      model_clear();
      m_last = 0;
    end else if (flush || hs) begin
      if (hs) m_last = m_i[S-1];
      model_clear();
    end else if (!(m_v[S-1] && !ready)) begin
      for (int s = S - 1; s > 0; s--) begin
        m_v[s] = m_v[s-1];
        m_p[s] = m_p[s-1];
        m_i[s] = m_i[s-1];
      end
      m_v[0] = wv;
      m_p[0] = wp;
      m_i[0] = wi;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    chk("model_valid", vout, m_v[S-1]);
    if (m_v[S-1]) begin
      chk("model_idx", iout, m_i[S-1]);
      chk("model_prio", pout, m_p[S-1]);
    end
  endtask

  task automatic wait_claim(output int got);
    int n;
    n = 0;
    while (vout !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk("claim_wait", vout, 1);
    got = int'(iout);
    step();
  endtask

  task automatic set_prio(input int i, input int p);
    pin[i*PW +: PW] = PW'(p);
  endtask

  initial begin
    int exp_tie [4];
    int got;
    int p;

    n_vec = 0;
    n_err = 0;
    m_last = 0;
    model_clear();
    rst = 1'b1; flush = 1'b0; ready = 1'b1;
    vin = '0; pin = '0; thr = '0;
    v64 = '0; p64 = '0;

    // Reset state
    tick();
    chk("rst_valid", vout, 0);
    chk("rst_prio", pout, 0);
    chk("rst_idx", iout, 0);
    chk("rst_valid64", vout64, 0);
    chk("rst_prio64", pout64, 0);
    chk("rst_idx64", iout64, 0);
    rst = 1'b0;

    // Ties on lines 1, 3, 6 at prio 7 with repeated claims
`ifdef IRQ_ARB_RR_EN
    exp_tie = '{1, 3, 6, 1};
`else
    exp_tie = '{1, 1, 1, 1};
`endif
    vin = 8'b0100_1010;
    set_prio(1, 7); set_prio(3, 7); set_prio(6, 7);
    for (int c = 0; c < 4; c++) begin
      wait_claim(got);
      chk("tie_claim", got, exp_tie[c]);
    end
    vin = '0; pin = '0;
    repeat (4) step();

    // Basic: lines 2 (prio 5) and 5 (prio 9)
    vin = 8'b0010_0100;
    set_prio(2, 5); set_prio(5, 9);
    repeat (2) begin
      step();
      chk("basic_early", vout, 0);
    end
    step();
    chk("basic_valid", vout, 1);
    chk("basic_idx", iout, 5);
    chk("basic_prio", pout, 9);
    vin = '0;
    repeat (3) begin
      step();
      chk("basic_gap", vout, 0);
    end
    repeat (2) step();

    // Threshold masking
    vin = 8'b0010_0100;
    thr = 4'd9;
    repeat (6) begin
      step();
      chk("thresh9_valid", vout, 0);
    end
    thr = 4'd4;
    repeat (3) step();
    chk("thresh4_valid", vout, 1);
    chk("thresh4_idx", iout, 5);
    vin = '0;
    repeat (4) step();
    vin = 8'b0000_0100;
    thr = 4'd5;
    repeat (6) begin
      step();
      chk("thresh5_valid", vout, 0);
    end
    thr = 4'hF;
    vin = 8'hFF;
    pin = 32'hFFFF_FFFF;
    repeat (5) begin
      step();
      chk("thresh_max_valid", vout, 0);
    end
    vin = '0; pin = '0; thr = '0;
    repeat (4) step();

    // Stall: held winner is not preempted by a later higher-priority line
    vin = 8'b0010_0100;
    set_prio(2, 5); set_prio(5, 9);
    ready = 1'b0;
    repeat (3) step();
    vin[7] = 1'b1;
    set_prio(7, 15);
    repeat (5) begin
      step();
      chk("stall_valid", vout, 1);
      chk("stall_idx", iout, 5);
      chk("stall_prio", pout, 9);
    end
    ready = 1'b1;
    repeat (3) begin
      step();
      chk("post_claim_gap", vout, 0);
    end
    step();
    chk("post_claim_valid", vout, 1);
    chk("post_claim_idx", iout, 7);
    chk("post_claim_prio", pout, 15);
    vin = '0; pin = '0;
    repeat (4) step();

    // Flush while stalled, then reset mid-stall and mid-pipeline
    vin = 8'b0010_0100;
    set_prio(2, 5); set_prio(5, 9);
    ready = 1'b0;
    repeat (3) step();
    chk("flush_pre", vout, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", vout, 0);
    repeat (3) step();
    chk("refill_valid", vout, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_stall_valid", vout, 0);
    chk("rst_stall_prio", pout, 0);
    chk("rst_stall_idx", iout, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pipe_valid", vout, 0);
    chk("rst_pipe_prio", pout, 0);
    chk("rst_pipe_idx", iout, 0);
    repeat (2) begin
      step();
      chk("rst_pipe_empty", vout, 0);
    end
    ready = 1'b1;
    vin = '0; pin = '0;
    repeat (4) step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        vin = N'($urandom);
        for (int i = 0; i < N; i++) set_prio(i, int'($urandom_range(0, 7)));
        thr = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 15)) : PW'($urandom_range(0, 2));
      end
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; ready = 1'b1;
    vin = '0; pin = '0; thr = '0;
    repeat (4) step();

    // Single-line sweep on the 64-line, output-register-only build
    for (int i = 0; i < N64; i++) begin
      p = int'($urandom_range(1, 255));
      v64 = '0;
      v64[i] = 1'b1;
      p64 = '0;
      p64[i*PW64 +: PW64] = PW64'(p);
      step();
      chk("sweep_valid", vout64, 1);
      chk("sweep_idx", iout64, i);
      chk("sweep_prio", pout64, p);
      v64 = '0;
      step();
      chk("sweep_clear", vout64, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
